// File: rtl/sram_async_ctrl.sv
// Synchronous front end for an asynchronous SRAM: one request per two clocks,
// registered chip pins, fixed three-clock read latency.
module sram_async_ctrl #(
  parameter int ADDR_BITS = 10,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req,
  output logic                 ready,
  input  logic                 write_enable,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [DATA_BITS-1:0] write_data,
  output logic                 write_done,
  output logic [DATA_BITS-1:0] read_data,
  output logic                 read_data_valid,
  output logic [ADDR_BITS-1:0] io_addr_bus,
  inout  wire  [DATA_BITS-1:0] io_data_bus,
  output logic                 io_we_n,
  output logic                 io_oe_n,
  output logic                 io_ce_n
);

  typedef enum logic {S_IDLE, S_ACCESS} state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic                 w_accept;
  logic                 w_launch;

  logic [ADDR_BITS-1:0] r_addr;
  logic [DATA_BITS-1:0] r_wdata;
  logic                 r_we;

  logic [ADDR_BITS-1:0] r_io_addr;
  logic [DATA_BITS-1:0] r_dout;
  logic                 r_drive;
  logic                 r_we_n;
  logic                 r_oe_n;
  logic                 r_ce_n;

  logic                 r_write_done;
  logic [DATA_BITS-1:0] r_cap;
  logic                 r_cap_valid;
  logic [DATA_BITS-1:0] r_read_data;
  logic                 r_read_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_launch     = 1'b0;
    ready        = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        ready = 1'b1;
        if (req) begin
          w_accept     = 1'b1;
          w_state_next = S_ACCESS;
        end
      end
      S_ACCESS: begin
        w_launch     = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
    end else if (w_accept) begin
      r_addr  <= addr;
      r_wdata <= write_data;
      r_we    <= write_enable;
    end
  end

  // Strobes are a single cycle wide: the FSM never launches on two adjacent edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_io_addr <= '0;
      r_dout    <= '0;
      r_drive   <= 1'b0;
      r_we_n    <= 1'b1;
      r_oe_n    <= 1'b1;
      r_ce_n    <= 1'b1;
    end else begin
      r_ce_n <= 1'b0;
      r_we_n <= ~(w_launch & r_we);
      r_oe_n <= ~(w_launch & ~r_we);
      if (w_launch) begin
        r_io_addr <= r_addr;
        if (r_we) begin
          r_drive <= 1'b1;
          r_dout  <= r_wdata;
        end else begin
          r_drive <= 1'b0;
        end
      end
    end
  end

  // Completion is keyed off the strobe that was low in the previous cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_write_done <= 1'b0;
      r_cap        <= '0;
      r_cap_valid  <= 1'b0;
      r_read_data  <= '0;
      r_read_valid <= 1'b0;
    end else begin
      r_write_done <= ~r_we_n;
      r_cap_valid  <= ~r_oe_n;
      if (~r_oe_n)     r_cap       <= io_data_bus;
      r_read_valid <= r_cap_valid;
      if (r_cap_valid) r_read_data <= r_cap;
    end
  end

  assign io_data_bus     = r_drive ? r_dout : 'z;
  assign io_addr_bus     = r_io_addr;
  assign io_we_n         = r_we_n;
  assign io_oe_n         = r_oe_n;
  assign io_ce_n         = r_ce_n;
  assign write_done      = r_write_done;
  assign read_data       = r_read_data;
  assign read_data_valid = r_read_valid;

endmodule

// File: tb/tb_sram_async_ctrl.sv
// Randomized bench for sram_async_ctrl with an SRAM pin model and an
// event-schedule reference model indexed by clock edge.
module tb_sram_async_ctrl;
  localparam int AB = 10;
  localparam int DB = 8;
  localparam int N  = 2048;

  logic          clk = 1'b0;
  logic          reset;
  logic          req;
  logic          ready;
  logic          write_enable;
  logic [AB-1:0] addr;
  logic [DB-1:0] write_data;
  logic          write_done;
  logic [DB-1:0] read_data;
  logic          read_data_valid;
  logic [AB-1:0] io_addr_bus;
  wire  [DB-1:0] io_data_bus;
  logic          io_we_n;
  logic          io_oe_n;
  logic          io_ce_n;

  sram_async_ctrl #(.ADDR_BITS(AB), .DATA_BITS(DB)) dut (
    .clk(clk), .reset(reset), .req(req), .ready(ready),
    .write_enable(write_enable), .addr(addr), .write_data(write_data),
    .write_done(write_done), .read_data(read_data),
    .read_data_valid(read_data_valid), .io_addr_bus(io_addr_bus),
    .io_data_bus(io_data_bus), .io_we_n(io_we_n), .io_oe_n(io_oe_n),
    .io_ce_n(io_ce_n)
  );

  always #5 clk = ~clk;

  // SRAM pin model
  logic [DB-1:0] sram_mem [1<<AB];
  assign io_data_bus = (!io_ce_n && !io_oe_n && io_we_n) ? sram_mem[io_addr_bus] : 'z;
  always @(posedge io_we_n) if (!io_ce_n) sram_mem[io_addr_bus] = io_data_bus;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  // Reference model: every accepted op schedules its pin, done and valid
  // events at fixed edge offsets from acceptance.
  int            cyc = 0;
  bit            m_ready = 1'b1;
  bit            m_ce_n  = 1'b1;
  logic [DB-1:0] ref_mem [1<<AB];
  bit            m_written [1<<AB];
  bit            ev_pin [N];
  bit            ev_we  [N];
  logic [AB-1:0] ev_addr [N];
  logic [DB-1:0] ev_data [N];
  bit            exp_wd [N];
  bit            exp_rv [N];
  logic [DB-1:0] exp_rd [N];

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (reset) begin
      m_ready = 1'b1;
      m_ce_n  = 1'b1;
      for (int i = cyc; i < N; i++) begin
        ev_pin[i] = 1'b0; exp_wd[i] = 1'b0; exp_rv[i] = 1'b0;
      end
    end else begin
      m_ce_n = 1'b0;
      if (m_ready && req) begin
        m_ready = 1'b0;
        ev_pin[cyc+1]  = 1'b1;
        ev_we[cyc+1]   = write_enable;
        ev_addr[cyc+1] = addr;
        ev_data[cyc+1] = write_data;
        if (write_enable) begin
          ref_mem[addr]   = write_data;
          m_written[addr] = 1'b1;
          exp_wd[cyc+2]   = 1'b1;
        end else begin
          exp_rv[cyc+3] = 1'b1;
          exp_rd[cyc+3] = ref_mem[addr];
        end
      end else begin
        m_ready = 1'b1;
      end
    end
  end

  logic [AB-1:0] cur_addr = '0;
  bit            cur_drv  = 1'b0;
  logic [DB-1:0] cur_data = '0;
  logic [DB-1:0] last_rd  = '0;

  always @(negedge clk) begin
    if (reset) begin
      cur_addr = '0; cur_drv = 1'b0; last_rd = '0;
    end
    if (ev_pin[cyc]) begin
      cur_addr = ev_addr[cyc];
      cur_drv  = ev_we[cyc];
      if (ev_we[cyc]) cur_data = ev_data[cyc];
    end
    check_eq("ready", ready, reset ? 1'b1 : m_ready);
    check_eq("ce_n", io_ce_n, reset ? 1'b1 : m_ce_n);
    check_eq("we_n", io_we_n, (ev_pin[cyc] && ev_we[cyc]) ? 1'b0 : 1'b1);
    check_eq("oe_n", io_oe_n, (ev_pin[cyc] && !ev_we[cyc]) ? 1'b0 : 1'b1);
    check_eq("addr_bus", io_addr_bus, cur_addr);
    if (cur_drv) check_eq("data_bus", io_data_bus, cur_data);
    check_eq("write_done", write_done, exp_wd[cyc]);
    check_eq("rd_valid", read_data_valid, exp_rv[cyc]);
    if (exp_rv[cyc]) last_rd = exp_rd[cyc];
    check_eq("read_data", read_data, last_rd);
  end

  task automatic drive(input logic we, input logic [AB-1:0] a, input logic [DB-1:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      req = 1'b1; write_enable = we; addr = a; write_data = d;
      @(posedge clk); #1;
    end
    req = 1'b0;
  endtask

  task automatic idle(input int n);
    req = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    reset = 1'b1; req = 1'b0; write_enable = 1'b0; addr = '0; write_data = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    idle(3);
    drive(1'b1, 10'h0AA, 8'hA1, 1); idle(3);
    drive(1'b0, 10'h0AA, 8'h00, 1); idle(4);
    drive(1'b1, 10'h101, 8'h51, 2);
    drive(1'b1, 10'h102, 8'h52, 2);
    drive(1'b1, 10'h103, 8'h53, 2); idle(3);
    drive(1'b0, 10'h101, 8'h00, 2);
    drive(1'b0, 10'h102, 8'h00, 1); idle(5);
    drive(1'b0, 10'h103, 8'h00, 1); idle(5);

    for (int i = 0; i < 400; i++) begin
      logic          we;
      logic [AB-1:0] a;
      req = ($urandom_range(0, 3) != 0);
      we  = 1'($urandom_range(0, 1));
      a   = ($urandom_range(0, 1) != 0) ? AB'($urandom_range(0, 15)) : AB'(10'h3F0 + $urandom_range(0, 15));
      if (!we && !m_written[a]) we = 1'b1;
      write_enable = we; addr = a; write_data = DB'($urandom);
      @(posedge clk); #1;
    end
    idle(4);

    // Abort a read while in ACCESS.
    req = 1'b1; write_enable = 1'b0; addr = 10'h103;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check_eq("rst_ready", ready, 1'b1);
    check_eq("rst_we_n", io_we_n, 1'b1);
    check_eq("rst_oe_n", io_oe_n, 1'b1);
    check_eq("rst_ce_n", io_ce_n, 1'b1);
    check_eq("rst_addr", io_addr_bus, 10'h000);
    check_eq("rst_wdone", write_done, 1'b0);
    check_eq("rst_valid", read_data_valid, 1'b0);
    check_eq("rst_rdata", read_data, 8'h00);
    req = 1'b0;
    @(posedge clk); @(posedge clk);
    #1 reset = 1'b0;
    idle(6);
    drive(1'b0, 10'h0AA, 8'h00, 1); idle(6);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
